// File: rtl/ram_93422_arb_pkg.sv
// Shared types and sizes for the 93422 SRAM arbiter.
package ram_93422_arb_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VRD,
        ST_CRD,
        ST_WSET,
        ST_WSTB,
        ST_WHLD
    } state_t;

endpackage

// File: rtl/ram_93422_arb.sv
// Arbiter and access sequencer for a single 256x4 asynchronous SRAM shared by
// a video scan reader (priority) and a CPU requester (req/ack handshake).
// Every RAM control pin is a flop output, so the async part never sees
// combinational glitches on its strobes.
module ram_93422_arb
    import ram_93422_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int WR_PULSE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [RAM_AW-1:0] vid_addr,
    output logic [RAM_DW-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [RAM_AW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_i,
    input  logic [RAM_DW-1:0] ram_d,
    output logic              ram_cs1_n,
    output logic              ram_cs2,
    output logic              ram_oe_n,
    output logic              ram_w_n
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] WCNT_LAST  = 2'(WR_PULSE - 1);

    state_t            r_state;
    logic [3:0]        r_starve;
    logic [1:0]        r_wcnt;
    logic              r_ack_done;
    logic              r_vid_lost;
    logic [RAM_AW-1:0] r_ram_a;
    logic [RAM_DW-1:0] r_ram_i;
    logic              r_ram_cs1_n;
    logic              r_ram_oe_n;
    logic              r_ram_w_n;
    logic [RAM_DW-1:0] r_vid_data;
    logic              r_vid_valid;
    logic              r_vid_miss;
    logic [RAM_DW-1:0] r_cpu_rdata;
    logic              r_cpu_ack;

    logic              w_grant_slot;
    logic              w_cpu_pend;
    logic              w_cpu_grant;
    logic              w_vid_grant;

    // Grant decision: only IDLE/VRD edges may start a new access; a CPU
    // request already acknowledged stays blocked until cpu_req drops.
    always_comb begin
        w_grant_slot = (r_state == ST_IDLE) || (r_state == ST_VRD);
        w_cpu_pend   = cpu_req && !r_ack_done;
        w_cpu_grant  = w_grant_slot && w_cpu_pend &&
                       (!vid_req || (r_starve == STARVE_LIM));
        w_vid_grant  = w_grant_slot && vid_req && !w_cpu_grant;
    end

    // Sequencer FSM with registered RAM controls and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_starve    <= 4'd0;
            r_wcnt      <= 2'd0;
            r_ack_done  <= 1'b0;
            r_vid_lost  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_i     <= '0;
            r_ram_cs1_n <= 1'b1;
            r_ram_oe_n  <= 1'b1;
            r_ram_w_n   <= 1'b1;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_vid_miss  <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_cpu_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            // A video request not granted this edge reports a miss one edge
            // later, lining up with where its data would have appeared.
            r_vid_lost  <= vid_req && !w_vid_grant;
            r_vid_miss  <= r_vid_lost;

            if (!cpu_req || w_cpu_grant) begin
                r_starve <= 4'd0;
            end else if (w_vid_grant && w_cpu_pend && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 4'd1;
            end

            if (!cpu_req) begin
                r_ack_done <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_VRD: begin
                    if (r_state == ST_VRD) begin
                        r_vid_data  <= ram_d;
                        r_vid_valid <= 1'b1;
                    end
                    if (w_cpu_grant) begin
                        r_ram_a     <= cpu_addr;
                        r_ram_cs1_n <= 1'b0;
                        r_ram_w_n   <= 1'b1;
                        if (cpu_we) begin
                            r_ram_i    <= cpu_wdata;
                            r_ram_oe_n <= 1'b1;
                            r_state    <= ST_WSET;
                        end else begin
                            r_ram_oe_n <= 1'b0;
                            r_state    <= ST_CRD;
                        end
                    end else if (w_vid_grant) begin
                        r_ram_a     <= vid_addr;
                        r_ram_cs1_n <= 1'b0;
                        r_ram_oe_n  <= 1'b0;
                        r_state     <= ST_VRD;
                    end else begin
                        r_ram_cs1_n <= 1'b1;
                        r_ram_oe_n  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_CRD: begin
                    r_cpu_rdata <= ram_d;
                    r_cpu_ack   <= 1'b1;
                    r_ack_done  <= 1'b1;
                    r_ram_cs1_n <= 1'b1;
                    r_ram_oe_n  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_WSET: begin
                    // Address and data have had a full cycle of setup.
                    r_ram_w_n <= 1'b0;
                    r_wcnt    <= 2'd0;
                    r_state   <= ST_WSTB;
                end
                ST_WSTB: begin
                    if (r_wcnt == WCNT_LAST) begin
                        r_ram_w_n <= 1'b1;
                        r_state   <= ST_WHLD;
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                ST_WHLD: begin
                    // Address/data held one cycle past the strobe release.
                    r_cpu_ack   <= 1'b1;
                    r_ack_done  <= 1'b1;
                    r_ram_cs1_n <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_ram_cs1_n <= 1'b1;
                    r_ram_oe_n  <= 1'b1;
                    r_ram_w_n   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_a     = r_ram_a;
    assign ram_i     = r_ram_i;
    assign ram_cs1_n = r_ram_cs1_n;
    assign ram_cs2   = 1'b1;
    assign ram_oe_n  = r_ram_oe_n;
    assign ram_w_n   = r_ram_w_n;
    assign vid_data  = r_vid_data;
    assign vid_valid = r_vid_valid;
    assign vid_miss  = r_vid_miss;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;

endmodule

// File: tb/tb_ram_93422_arb.sv
// Directed bench for ram_93422_arb with a behavioural 256x4 async RAM.
module tb_ram_93422_arb;

    logic       clk;
    logic       reset;
    logic       vid_req;
    logic [7:0] vid_addr;
    logic [3:0] vid_data;
    logic       vid_valid;
    logic       vid_miss;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic [3:0] cpu_rdata;
    logic       cpu_ack;
    logic [7:0] ram_a;
    logic [3:0] ram_i;
    logic [3:0] ram_d;
    logic       ram_cs1_n;
    logic       ram_cs2;
    logic       ram_oe_n;
    logic       ram_w_n;

    logic [3:0] mem [256];
    int n_cmp;
    int n_err;

    ram_93422_arb #(.STARVE_MAX(4), .WR_PULSE(1)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_a(ram_a), .ram_i(ram_i), .ram_d(ram_d),
        .ram_cs1_n(ram_cs1_n), .ram_cs2(ram_cs2),
        .ram_oe_n(ram_oe_n), .ram_w_n(ram_w_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous read port of the RAM model.
    assign ram_d = (!ram_cs1_n && ram_cs2 && !ram_oe_n && ram_w_n) ? mem[ram_a] : 4'h0;

    function automatic logic [3:0] pat(input logic [7:0] a);
        return a[3:0] + a[7:4];
    endfunction

    // Advance one clock; the RAM latches data during any cycle its strobe is low.
    task automatic tick;
        if (!ram_w_n && !ram_cs1_n && ram_cs2) mem[ram_a] = ram_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({ram_cs1_n, ram_oe_n, ram_w_n, ram_cs2} !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_ctrl: cs1_n/oe_n/w_n/cs2=%b expected 1111", {ram_cs1_n, ram_oe_n, ram_w_n, ram_cs2});
        end
        n_cmp++;
        if ({ram_a, ram_i, vid_data, cpu_rdata} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_data: a/i/vdata/rdata=%h expected 00000", {ram_a, ram_i, vid_data, cpu_rdata});
        end
        n_cmp++;
        if ({vid_valid, vid_miss, cpu_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: valid/miss/ack=%b expected 000", {vid_valid, vid_miss, cpu_ack});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_video_sweep;
        vid_req  = 1'b1;
        vid_addr = 8'd0;
        tick();
        n_cmp++;
        if (vid_valid !== 1'b0) begin
            n_err++;
            $display("FAIL vid_latency: vid_valid=%b expected 0", vid_valid);
        end
        for (int k = 1; k <= 256; k++) begin
            vid_req  = (k < 256);
            vid_addr = 8'(k);
            tick();
            n_cmp++;
            if (vid_valid !== 1'b1 || vid_data !== pat(8'(k - 1)) || cpu_ack !== 1'b0) begin
                n_err++;
                $display("FAIL vid_sweep[%0d]: valid=%b data=%h ack=%b expected 1 %h 0",
                         k - 1, vid_valid, vid_data, cpu_ack, pat(8'(k - 1)));
            end
        end
        tick();
        n_cmp++;
        if (vid_valid !== 1'b0 || vid_miss !== 1'b0) begin
            n_err++;
            $display("FAIL vid_stop: valid=%b miss=%b expected 0 0", vid_valid, vid_miss);
        end
    endtask

    task automatic test_write;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h5A; cpu_wdata = 4'hC;
        tick();
        n_cmp++;
        if ({ram_a, ram_i, ram_cs1_n, ram_oe_n, ram_w_n, cpu_ack} !== {8'h5A, 4'hC, 4'b0110}) begin
            n_err++;
            $display("FAIL wr_setup: a=%h i=%h cs/oe/w/ack=%b expected 5a c 0110",
                     ram_a, ram_i, {ram_cs1_n, ram_oe_n, ram_w_n, cpu_ack});
        end
        tick();
        n_cmp++;
        if ({ram_a, ram_i, ram_w_n, cpu_ack} !== {8'h5A, 4'hC, 2'b00}) begin
            n_err++;
            $display("FAIL wr_strobe: a=%h i=%h w_n=%b ack=%b expected 5a c 0 0", ram_a, ram_i, ram_w_n, cpu_ack);
        end
        tick();
        n_cmp++;
        if ({ram_a, ram_i, ram_w_n, cpu_ack} !== {8'h5A, 4'hC, 2'b10}) begin
            n_err++;
            $display("FAIL wr_hold: a=%h i=%h w_n=%b ack=%b expected 5a c 1 0", ram_a, ram_i, ram_w_n, cpu_ack);
        end
        tick();
        n_cmp++;
        if ({cpu_ack, ram_w_n, ram_cs1_n} !== 3'b111) begin
            n_err++;
            $display("FAIL wr_ack: ack/w_n/cs1_n=%b expected 111", {cpu_ack, ram_w_n, ram_cs1_n});
        end
        cpu_req = 1'b0;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_ack_pulse: ack=%b expected 0", cpu_ack);
        end
        vid_req = 1'b1; vid_addr = 8'h5A;
        tick();
        vid_req = 1'b0;
        tick();
        n_cmp++;
        if (vid_valid !== 1'b1 || vid_data !== 4'hC) begin
            n_err++;
            $display("FAIL wr_readback: valid=%b data=%h expected 1 c", vid_valid, vid_data);
        end
        tick();
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h5A;
        tick();
        n_cmp++;
        if ({ram_a, ram_cs1_n, ram_oe_n, ram_w_n, cpu_ack} !== {8'h5A, 4'b0010}) begin
            n_err++;
            $display("FAIL rd_slot: a=%h cs/oe/w/ack=%b expected 5a 0010", ram_a, {ram_cs1_n, ram_oe_n, ram_w_n, cpu_ack});
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 4'hC) begin
            n_err++;
            $display("FAIL rd_ack: ack=%b rdata=%h expected 1 c", cpu_ack, cpu_rdata);
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0 || ram_cs1_n !== 1'b1) begin
            n_err++;
            $display("FAIL rd_no_regrant: ack=%b cs1_n=%b expected 0 1", cpu_ack, ram_cs1_n);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        logic [3:0] tab [10];
        // {vid_valid, vid_miss, cpu_ack, ram_w_n} after edges 1..10
        tab = '{4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                4'b0100, 4'b0101, 4'b0111, 4'b0101, 4'b1001};
        cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 4'hA;
        vid_req = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            vid_addr = 8'h10 + 8'(e);
            cpu_req  = (e <= 8);
            tick();
            n_cmp++;
            if ({vid_valid, vid_miss, cpu_ack, ram_w_n} !== tab[e - 1]) begin
                n_err++;
                $display("FAIL starve_flags[e%0d]: valid/miss/ack/w_n=%b expected %b",
                         e, {vid_valid, vid_miss, cpu_ack, ram_w_n}, tab[e - 1]);
            end
            if (e <= 4) begin
                n_cmp++;
                if (ram_a !== 8'h10 + 8'(e)) begin
                    n_err++;
                    $display("FAIL starve_vgrant[e%0d]: ram_a=%h expected %h", e, ram_a, 8'h10 + 8'(e));
                end
            end else if (e <= 8) begin
                n_cmp++;
                if (ram_a !== 8'h33 || ram_i !== 4'hA) begin
                    n_err++;
                    $display("FAIL starve_force[e%0d]: a=%h i=%h expected 33 a", e, ram_a, ram_i);
                end
            end
            if ((e >= 2 && e <= 5) || e == 10) begin
                n_cmp++;
                if (vid_data !== pat(8'h10 + 8'(e - 1))) begin
                    n_err++;
                    $display("FAIL starve_vdata[e%0d]: data=%h expected %h", e, vid_data, pat(8'h10 + 8'(e - 1)));
                end
            end
        end
        vid_req = 1'b0;
        tick();
        tick();
        vid_req = 1'b1; vid_addr = 8'h33;
        tick();
        vid_req = 1'b0;
        tick();
        n_cmp++;
        if (vid_valid !== 1'b1 || vid_data !== 4'hA) begin
            n_err++;
            $display("FAIL starve_readback: valid=%b data=%h expected 1 a", vid_valid, vid_data);
        end
        tick();
    endtask

    task automatic test_simultaneous;
        vid_req = 1'b1; vid_addr = 8'h20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        tick();
        n_cmp++;
        if (ram_a !== 8'h20 || ram_oe_n !== 1'b0 || cpu_ack !== 1'b0) begin
            n_err++;
            $display("FAIL simul_vid_first: a=%h oe_n=%b ack=%b expected 20 0 0", ram_a, ram_oe_n, cpu_ack);
        end
        vid_req = 1'b0;
        tick();
        n_cmp++;
        if (ram_a !== 8'h33 || vid_valid !== 1'b1 || vid_data !== pat(8'h20)) begin
            n_err++;
            $display("FAIL simul_cpu_next: a=%h valid=%b data=%h expected 33 1 %h", ram_a, vid_valid, vid_data, pat(8'h20));
        end
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 4'hA) begin
            n_err++;
            $display("FAIL simul_cpu_ack: ack=%b rdata=%h expected 1 a", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h44; cpu_wdata = 4'h9;
        tick();
        tick();
        n_cmp++;
        if (ram_w_n !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wr_strobe: w_n=%b expected 0", ram_w_n);
        end
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        n_cmp++;
        if ({ram_w_n, ram_cs1_n, ram_oe_n, cpu_ack} !== 4'b1110) begin
            n_err++;
            $display("FAIL rst_wr_abort: w_n/cs1_n/oe_n/ack=%b expected 1110", {ram_w_n, ram_cs1_n, ram_oe_n, cpu_ack});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b0 || ram_cs1_n !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wr_idle: ack=%b cs1_n=%b expected 0 1", cpu_ack, ram_cs1_n);
        end
        cpu_req = 1'b1; cpu_wdata = 4'h3;
        tick();
        tick();
        n_cmp++;
        if (ram_w_n !== 1'b0 || ram_a !== 8'h44 || ram_i !== 4'h3) begin
            n_err++;
            $display("FAIL rst_fresh_strobe: w_n=%b a=%h i=%h expected 0 44 3", ram_w_n, ram_a, ram_i);
        end
        tick();
        tick();
        n_cmp++;
        if (cpu_ack !== 1'b1) begin
            n_err++;
            $display("FAIL rst_fresh_ack: ack=%b expected 1", cpu_ack);
        end
        cpu_req = 1'b0;
        tick();
        vid_req = 1'b1; vid_addr = 8'h44;
        tick();
        vid_req = 1'b0;
        tick();
        n_cmp++;
        if (vid_valid !== 1'b1 || vid_data !== 4'h3) begin
            n_err++;
            $display("FAIL rst_fresh_readback: valid=%b data=%h expected 1 3", vid_valid, vid_data);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = 8'h00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 4'h0;
        for (int a = 0; a < 256; a++) mem[a] = pat(8'(a));
        test_reset();
        test_video_sweep();
        test_write();
        test_cpu_read();
        test_starvation();
        test_simultaneous();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
